// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bus between the datapath (master) and the memory responder (slave).
interface mem_responder_if;
    logic        mem_en;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] sw;
    logic [15:0] rdata;
    logic        r;
    logic [15:0] hex_out;
    logic        err;
    modport master (output mem_en, we, addr, wdata, sw, input rdata, r, hex_out, err);
    modport slave  (input mem_en, we, addr, wdata, sw, output rdata, r, hex_out, err);
endinterface

// File: rtl/mem_responder.sv
// mem_responder: fixed wait-state SRAM responder with one memory-mapped I/O word and a sticky range error.
module mem_responder #(
    parameter int          ADDR_W  = 8,
    parameter int          WAIT    = 2,
    parameter logic [15:0] IO_ADDR = 16'hFFFF
) (
    input logic             clk,
    input logic             rst_n,
    mem_responder_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_RELEASE} state_t;
    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, hex_q, hex_d;
    logic        we_q, we_d, err_q, err_d;
    logic [15:0] mem [2**ADDR_W];
    logic        capture, access, is_io, is_sram;
    assign capture = state_q == S_IDLE && bus.mem_en;
    assign access  = state_q == S_WAIT && cnt_q == 3'd0;
    assign is_io   = addr_q == IO_ADDR;
    assign is_sram = !is_io && (addr_q >> ADDR_W) == 16'd0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            hex_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            hex_q   <= hex_d;
            err_q   <= err_d;
        end
    end
    // Storage is not reset; state is IDLE during reset so no write can slip through.
    always_ff @(posedge clk) begin
        if (access && we_q && is_sram) mem[addr_q[ADDR_W-1:0]] <= wdata_q;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = bus.mem_en ? S_WAIT : S_IDLE;
            S_WAIT:  state_d = cnt_q == 3'd0 ? S_DONE : S_WAIT;
            default: state_d = bus.mem_en ? S_RELEASE : S_IDLE;
        endcase
    end
    always_comb begin
        addr_d  = capture ? bus.addr : addr_q;
        wdata_d = capture ? bus.wdata : wdata_q;
        we_d    = capture ? bus.we : we_q;
        cnt_d   = capture ? 3'(WAIT - 1) : (state_q == S_WAIT && cnt_q != 3'd0) ? cnt_q - 3'd1 : cnt_q;
        rdata_d = !(access && !we_q) ? rdata_q : is_io ? bus.sw : is_sram ? mem[addr_q[ADDR_W-1:0]] : 16'h0000;
        hex_d   = access && we_q && is_io ? wdata_q : hex_q;
        err_d   = err_q | (access && !is_io && !is_sram);
    end
    always_comb begin
        bus.r       = state_q == S_DONE;
        bus.rdata   = rdata_q;
        bus.hex_out = hex_q;
        bus.err     = err_q;
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scoreboard bench for mem_responder with default parameters.
module tb_mem_responder;
    localparam int WAIT = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [15:0] exp_q [$];
    mem_responder_if bus();
    mem_responder #(.ADDR_W(8), .WAIT(WAIT), .IO_ADDR(16'hFFFF)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // Drives one access, expects R after WAIT edges, then holds MEM_EN for hold cycles.
    // tamper alters the bus and drops MEM_EN right after the capture edge.
    task automatic txn(input logic w, input logic [15:0] a, input logic [15:0] d, input logic [15:0] exp_rd, input int hold, input bit tamper);
        int c = 0;
        @(negedge clk);
        bus.mem_en = 1'b1;
        bus.we = w;
        bus.addr = a;
        bus.wdata = d;
        exp_q.push_back(exp_rd);
        do begin
            @(negedge clk);
            c++;
            if (tamper && c == 1) begin
                bus.addr = ~a;
                bus.wdata = ~d;
                bus.we = ~w;
                bus.mem_en = 1'b0;
            end
        end while (!bus.r && c < 12);
        chk("r_pulse", 32'(bus.r), 32'd1);
        chk("latency", 32'(c), 32'(WAIT + 1));
        chk("rdata", 32'(bus.rdata), 32'(exp_q.pop_front()));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("r_held_low", 32'(bus.r), 32'd0);
        end
        if (hold > 0) chk("state_release", 32'(dut.state_q), 32'd3);
        bus.mem_en = 1'b0;
        @(negedge clk);
        chk("r_after", 32'(bus.r), 32'd0);
        chk("state_idle", 32'(dut.state_q), 32'd0);
    endtask
    initial begin
        bus.mem_en = 1'b0;
        bus.we = 1'b0;
        bus.addr = '0;
        bus.wdata = '0;
        bus.sw = 16'h00A5;
        repeat (2) @(negedge clk);
        chk("rst_rdata", 32'(bus.rdata), 32'h0);
        chk("rst_hex", 32'(bus.hex_out), 32'h0);
        chk("rst_err", 32'(bus.err), 32'h0);
        chk("rst_r", 32'(bus.r), 32'h0);
        rst_n = 1'b1;
        txn(1'b1, 16'h0012, 16'hBEEF, 16'h0000, 0, 1'b0);
        txn(1'b0, 16'h0012, 16'h0000, 16'hBEEF, 0, 1'b0);
        chk("err_clean", 32'(bus.err), 32'h0);
        txn(1'b0, 16'hFFFF, 16'h0000, 16'h00A5, 0, 1'b0);
        txn(1'b1, 16'hFFFF, 16'h1234, 16'h00A5, 0, 1'b0);
        chk("hex_write", 32'(bus.hex_out), 32'h1234);
        txn(1'b1, 16'h0003, 16'h0000, 16'h00A5, 0, 1'b0);
        txn(1'b1, 16'h0000, 16'h7777, 16'h00A5, 0, 1'b0);
        txn(1'b0, 16'h0100, 16'h0000, 16'h0000, 0, 1'b0);
        chk("err_set", 32'(bus.err), 32'h1);
        txn(1'b1, 16'h0100, 16'hDEAD, 16'h0000, 0, 1'b0);
        chk("hex_untouched", 32'(bus.hex_out), 32'h1234);
        txn(1'b0, 16'h0000, 16'h0000, 16'h7777, 0, 1'b0);
        chk("err_sticky", 32'(bus.err), 32'h1);
        txn(1'b0, 16'h0012, 16'h0000, 16'hBEEF, 4, 1'b0);
        // Abort a write mid-wait: outputs clear at once and the word keeps its old value.
        @(negedge clk);
        bus.mem_en = 1'b1;
        bus.we = 1'b1;
        bus.addr = 16'h0003;
        bus.wdata = 16'h5555;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_rdata", 32'(bus.rdata), 32'h0);
        chk("abort_hex", 32'(bus.hex_out), 32'h0);
        chk("abort_err", 32'(bus.err), 32'h0);
        chk("abort_r", 32'(bus.r), 32'h0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_r_hold", 32'(bus.r), 32'h0);
        end
        bus.mem_en = 1'b0;
        rst_n = 1'b1;
        txn(1'b0, 16'h0003, 16'h0000, 16'h0000, 0, 1'b0);
        txn(1'b1, 16'h0020, 16'hA1A1, 16'h0000, 0, 1'b1);
        chk("tamper_err", 32'(bus.err), 32'h0);
        txn(1'b0, 16'h0020, 16'h0000, 16'hA1A1, 0, 1'b0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
